// File: rtl/load_store_unit.sv
// Purpose: bridges execute-stage byte/half/word loads and stores onto a word-organised,
//          byte-lane-writable data memory; returns sign- or zero-extended load data.
// Latency: response 2 cycles after acceptance, 3 for a split access, 1 for an error.
// Backpressure: req_ready is high only when idle; responses are single-cycle pulses that
//               the consumer must take.
// Build option: define LSU_MISALIGNED_SPLIT_EN to split word-straddling accesses into two
//               word accesses; without it they are rejected with resp_error.
// Ports: clk, reset (async, active-high); req_* request handshake; resp_* response pulse;
//        mem_* word access (enable, word address, lane enables, lane-aligned data);
//        mem_read_value is combinational read data for the word currently enabled.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-3:0] mem_word_addr,
  output logic [3:0]            mem_write_enable,
  output logic [31:0]           mem_write_value,
  input  logic [31:0]           mem_read_value
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state;

  // Request fields still needed after acceptance.
  logic       write_q;
  logic       unsigned_q;
  logic [1:0] size_q;
  logic [1:0] off_q;

  // Lane mask and data window of the incoming request.
  logic [1:0]  off;
  logic [7:0]  lane_base;
  logic [7:0]  mask;
  logic [31:0] data_lo;
  logic        split;
  logic        reject;

  assign off     = req_addr[1:0];
  assign data_lo = req_wdata << {off, 3'b000};
  assign split   = |mask[7:4];

  always_comb begin
    case (req_size)
      2'b00:   lane_base = 8'b0000_0001;
      2'b01:   lane_base = 8'b0000_0011;
      default: lane_base = 8'b0000_1111;
    endcase
    mask = lane_base << off;
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [ADDR_WIDTH-3:0] ONE_WORD = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-3:0] word_q;
  logic                  split_q;
  logic [3:0]            mask_hi_q;
  logic [31:0]           data_hi_q;
  logic [31:0]           buf_lo;
  logic [31:0]           data_hi;

  // Bytes shifted past lane 3 land in the next word; a shift of 32 (off=0) yields zero.
  assign data_hi = req_wdata >> (6'd32 - {1'b0, off, 3'b000});
  assign reject  = (req_size == 2'b11);
`else
  assign reject  = (req_size == 2'b11) | split;
`endif

  assign req_ready = (state == IDLE);

  // Align the read window down to the request offset, then size-extend.
  function automatic logic [31:0] extend_load(input logic [63:0] win, input logic [1:0] offs,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(win >> {offs, 3'b000});
    case (size)
      2'b00:   extend_load = {{24{sh[7] & ~uns}}, sh[7:0]};
      2'b01:   extend_load = {{16{sh[15] & ~uns}}, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      write_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      size_q           <= 2'b00;
      off_q            <= 2'b00;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_error       <= 1'b0;
      mem_enable       <= 1'b0;
      mem_word_addr    <= '0;
      mem_write_enable <= 4'h0;
      mem_write_value  <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      word_q           <= '0;
      split_q          <= 1'b0;
      mask_hi_q        <= 4'h0;
      data_hi_q        <= 32'h0;
      buf_lo           <= 32'h0;
`endif
    end else begin
      // Every output is a one-cycle pulse unless a state below re-asserts it.
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_error       <= 1'b0;
      mem_enable       <= 1'b0;
      mem_word_addr    <= '0;
      mem_write_enable <= 4'h0;
      mem_write_value  <= 32'h0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            off_q      <= off;
`ifdef LSU_MISALIGNED_SPLIT_EN
            word_q     <= req_addr[ADDR_WIDTH-1:2];
            split_q    <= split;
            mask_hi_q  <= mask[7:4];
            data_hi_q  <= data_hi;
`endif
            if (reject) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state            <= ACC0;
              mem_enable       <= 1'b1;
              mem_word_addr    <= req_addr[ADDR_WIDTH-1:2];
              mem_write_enable <= req_write ? mask[3:0] : 4'h0;
              mem_write_value  <= data_lo;
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          buf_lo <= mem_read_value;
          if (split_q) begin
            state            <= ACC1;
            mem_enable       <= 1'b1;
            mem_word_addr    <= word_q + ONE_WORD;
            mem_write_enable <= write_q ? mask_hi_q : 4'h0;
            mem_write_value  <= data_hi_q;
          end else
`endif
          begin
            state      <= RESP;
            resp_valid <= 1'b1;
            if (!write_q)
              resp_rdata <= extend_load({32'h0, mem_read_value}, off_q, size_q, unsigned_q);
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          if (!write_q)
            resp_rdata <= extend_load({mem_read_value, buf_lo}, off_q, size_q, unsigned_q);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the CPU execute stage to the word-organised data memory built from byte-lane-writable memory words. Accepts one byte, halfword or word load/store per handshake. Converts it into word-address, byte-enable and lane-aligned write-data accesses, and returns sign- or zero-extended load data. Misaligned accesses that straddle two words can be split into two memory accesses (see Configuration).

## Interface
- `ADDR_WIDTH`, default 32: byte-address width. The word address is `ADDR_WIDTH-2` bits.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend the load result (otherwise sign-extend).
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `resp_valid` out 1: one-cycle response pulse, issued for every accepted request.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_error` out 1: request illegal or unsupported. No memory access was made.
- `mem_enable` out 1: memory word selected.
- `mem_word_addr` out ADDR_WIDTH-2: selected word.
- `mem_write_enable` out 4: byte-lane write enables. Bit i covers bits 8i+7:8i.
- `mem_write_value` out 32: lane-aligned write data.
- `mem_read_value` in 32: word read data. Combinational, valid in the same cycle as `mem_enable`.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- Request capture:
  - On `req_valid & req_ready`, latch the request into internal registers.
  - Let `off = req_addr[1:0]`. Let `nb` = 1/2/4 for size 00/01/10.
- Window computation:
  - 8-lane mask: `m = ((1<<nb)-1) << off`.
  - 64-bit data window: `d = {32'b0, req_wdata} << (8*off)`.
  - Word N uses `m[3:0]` and `d[31:0]`. Word N+1 uses `m[7:4]` and `d[63:32]`.
  - `split = |m[7:4]`.
- IDLE transitions:
  - If `req_size==11`: go to RESP with error.
  - Else if `split` and the macro is absent: go to RESP with error.
  - Else: go to ACC0.
- ACC0:
  - Drives `mem_enable=1` and `mem_word_addr = addr[ADDR_WIDTH-1:2]`.
  - Drives `mem_write_enable = write ? m[3:0] : 0` and `mem_write_value = d[31:0]`.
  - Loads capture `mem_read_value` into buffer bits 31:0.
  - Goes to ACC1 if `split`, else to RESP.
- ACC1:
  - Same as ACC0, but uses word N+1 (wraps modulo 2^(ADDR_WIDTH-2)), `m[7:4]` and `d[63:32]`.
  - Loads capture into buffer bits 63:32.
  - Goes to RESP.
- RESP:
  - `resp_valid=1`.
  - For a load, `resp_rdata` = (buffer >> 8*off), truncated to `nb` bytes, then extended per `req_unsigned`. Word loads are unaffected by `req_unsigned`.
  - Goes to IDLE.
- Outside ACC0/ACC1, all `mem_*` outputs are 0, so no stray writes occur.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_error=0`, all `mem_*` outputs 0.
- Reset mid-operation: return to IDLE immediately. A pending ACC1 write is dropped. An ACC0 write already clocked is not undone.

## Timing
- Request accepted at edge 0. ACC0 is cycle 1 (the memory write occurs at edge 1). `resp_valid` is in cycle 2.
- Split access: ACC1 is cycle 2, `resp_valid` is in cycle 3.
- Error: `resp_valid` with `resp_error` in cycle 1.
- `req_ready` is low from the cycle after acceptance through RESP. It returns high in the cycle after RESP, so back-to-back requests are accepted every 3 cycles (4 if split).
- No response backpressure: the consumer must take `resp_*` in the RESP cycle.
- `resp_rdata` and `resp_error` are valid only while `resp_valid=1`, and are 0 otherwise.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined: straddling requests perform ACC0 then ACC1, as described above.
- Not defined:
  - Any request with `split=1` returns `resp_error=1` in cycle 1 with no memory access.
  - ACC1 and the upper buffer half are omitted. Non-straddling misaligned accesses (e.g. a half at off=1) still succeed.

## Test plan
- Byte store, addr 0x00000006, wdata 0x000000AB:
  - ACC0 drives word 0x1, we 0100, value 0x00AB0000.
  - `resp_valid` in cycle 2 with `rdata=0`.
- Load-extension checks, with word 0x1 holding 0x80AB1234:
  - Signed half load at addr 0x6 → `rdata=0xFFFF80AB`.
  - Unsigned half load at addr 0x6 → `rdata=0x000080AB`.
  - Signed byte load at addr 0x4 → `rdata=0x00000034`.
- With the macro, word store 0x11223344 at addr 0x0000000B:
  - ACC0: word 0x2, we 1000, value 0x44000000.
  - ACC1: word 0x3, we 0111, value 0x00112233.
  - `resp_valid` in cycle 3.
  - Without the macro: `resp_error=1` in cycle 1 and `mem_enable` never asserts.
- `req_size=11`, any address → `resp_error=1` in cycle 1, no access, `req_ready` high again in cycle 2.
- Split wrap at addr 0xFFFFFFFE, word load (macro on) → ACC0 at word 0x3FFFFFFF, ACC1 at word 0x0.
- Assert `reset` during ACC0 of a split store → ACC1 write never occurs. All outputs hold their reset values while `reset` is high, and a new request is accepted in the first cycle after `reset` deasserts.
